// File: rtl/cmd_rx_pkg.sv
// Package: cmd_rx_pkg
// Shared types and helpers for the serial command frame receiver.
//   rx_state_t : receiver FSM states
//   rx_err_t   : error codes reported on err_code
//   even_par() : even-parity bit over a word (zero-extended to 32 bits)
package cmd_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        DRAIN,
        ISSUE,
        STROBE,
        GAP
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SHORT,
        ERR_LONG,
        ERR_PAR_BUSY
    } rx_err_t;

    // Bit that makes the total number of ones (word + bit) even.
    function automatic logic even_par(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/cmd_strob_timer.sv
// Module: cmd_strob_timer
// Loadable down-counter timing the strobe-high and gap-low phases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length minus one
//   done       : counter has reached zero (last cycle of the phase)
module cmd_strob_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/cmd_frame_receiver.sv
// Module: cmd_frame_receiver
// Deserialises one framed address word (MSB first), then issues one strobe
// burst to the downstream decoder. Malformed frames, and frames arriving
// while a strobe/gap is in progress, are rejected with an error code.
// Optional feature: define CMD_RX_PARITY_EN to expect a trailing even-parity bit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ser_frame  : high for the whole frame; a low sample ends it
//   ser_valid  : ser_data carries a valid bit this cycle
//   ser_data   : serial data, MSB first
//   addr_out   : last accepted address word
//   strob_out  : strobe to the decoder, STROBE_LEN cycles high
//   busy       : high during ISSUE, STROBE and GAP
//   err_out    : one-cycle pulse on a rejected frame
//   err_code   : 0 none, 1 short, 2 long, 3 parity/busy; held until next frame end
module cmd_frame_receiver #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STROBE_LEN = 1,
    parameter int unsigned GAP_CYC    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_frame,
    input  logic              ser_valid,
    input  logic              ser_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic              strob_out,
    output logic              busy,
    output logic              err_out,
    output logic [1:0]        err_code
);
    import cmd_rx_pkg::*;

`ifdef CMD_RX_PARITY_EN
    localparam int unsigned NBITS = ADDR_W + 1;
`else
    localparam int unsigned NBITS = ADDR_W;
`endif
    localparam int unsigned CNT_W = $clog2(NBITS + 1);
    localparam int unsigned TMAX  = (STROBE_LEN > GAP_CYC) ? STROBE_LEN : GAP_CYC;
    localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CNT_W-1:0] NBITS_C     = CNT_W'(NBITS);
    localparam logic [TW-1:0]    STROBE_LOAD = TW'(STROBE_LEN - 1);
    localparam logic [TW-1:0]    GAP_LOAD    = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    rx_state_t         state_q,      state_d;
    rx_err_t           err_code_q,   err_code_d;
    logic [NBITS-1:0]  shreg_q,      shreg_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              strob_q,      strob_d;
    logic              busy_q,       busy_d;
    logic              err_q,        err_d;
    logic              busy_frame_q, busy_frame_d;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_done;

    cmd_strob_timer #(.CNT_W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        err_d        = 1'b0;
        busy_frame_d = busy_frame_q;
        tmr_load     = 1'b0;
        tmr_val      = STROBE_LOAD;

        case (state_q)
            IDLE: begin
                // A frame that began while busy is swallowed here until it ends.
                if (busy_frame_q) begin
                    if (!ser_frame) begin
                        busy_frame_d = 1'b0;
                        err_d        = 1'b1;
                        err_code_d   = ERR_PAR_BUSY;
                    end
                end else if (ser_frame) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    if (ser_valid) begin
                        shreg_d = {shreg_q[NBITS-2:0], ser_data};
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            SHIFT: begin
                if (!ser_frame) begin
                    if (cnt_q == NBITS_C) begin
`ifdef CMD_RX_PARITY_EN
                        if (even_par(32'(shreg_q[NBITS-1:1])) != shreg_q[0]) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_PAR_BUSY;
                            state_d    = IDLE;
                        end else begin
                            state_d = ISSUE;
                        end
`else
                        state_d = ISSUE;
`endif
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_SHORT;
                        state_d    = IDLE;
                    end
                end else if (ser_valid) begin
                    if (cnt_q == NBITS_C) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LONG;
                        state_d    = DRAIN;
                    end else begin
                        shreg_d = {shreg_q[NBITS-2:0], ser_data};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!ser_frame) begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                addr_d     = shreg_q[NBITS-1 -: ADDR_W];
                err_code_d = ERR_NONE;
                tmr_load   = 1'b1;
                tmr_val    = STROBE_LOAD;
                state_d    = STROBE;
            end
            STROBE: begin
                if (tmr_done) begin
                    if (GAP_CYC > 0) begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        state_d  = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Track frames that start while busy; the flag survives into IDLE so a
        // frame still high when GAP ends is treated as a busy frame.
        if (state_q inside {ISSUE, STROBE, GAP}) begin
            if (ser_frame) begin
                busy_frame_d = 1'b1;
            end else if (busy_frame_q) begin
                busy_frame_d = 1'b0;
                err_d        = 1'b1;
                err_code_d   = ERR_PAR_BUSY;
            end
        end

        strob_d = (state_d == STROBE);
        busy_d  = (state_d inside {ISSUE, STROBE, GAP});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            err_code_q   <= ERR_NONE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            strob_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            strob_q      <= strob_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            busy_frame_q <= busy_frame_d;
        end
    end

    assign addr_out  = addr_q;
    assign strob_out = strob_q;
    assign busy      = busy_q;
    assign err_out   = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_cmd_frame_receiver.sv
// Testbench: tb_cmd_frame_receiver
// Drives two receivers from one serial stream: one with STROBE_LEN=1/GAP_CYC=1
// and one with STROBE_LEN=4/GAP_CYC=2. Expected addresses and error codes are
// queued when a frame is driven and consumed as each receiver produces them.
module tb_cmd_frame_receiver;

    localparam int unsigned AW = 5;
`ifdef CMD_RX_PARITY_EN
    localparam int unsigned NB = AW + 1;
`else
    localparam int unsigned NB = AW;
`endif
    localparam int SL0 = 1;
    localparam int GC0 = 1;
    localparam int SL1 = 4;
    localparam int GC1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser_frame = 1'b0;
    logic ser_valid = 1'b0;
    logic ser_data = 1'b0;

    logic [AW-1:0] addr_a, addr_b;
    logic          strob_a, strob_b, busy_a, busy_b, err_a, err_b;
    logic [1:0]    code_a, code_b;

    always #5 clk = ~clk;

    cmd_frame_receiver #(.ADDR_W(AW), .STROBE_LEN(SL0), .GAP_CYC(GC0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ser_frame(ser_frame), .ser_valid(ser_valid),
        .ser_data(ser_data), .addr_out(addr_a), .strob_out(strob_a), .busy(busy_a),
        .err_out(err_a), .err_code(code_a)
    );

    cmd_frame_receiver #(.ADDR_W(AW), .STROBE_LEN(SL1), .GAP_CYC(GC1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ser_frame(ser_frame), .ser_valid(ser_valid),
        .ser_data(ser_data), .addr_out(addr_b), .strob_out(strob_b), .busy(busy_b),
        .err_out(err_b), .err_code(code_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;

    logic [AW-1:0] exp_addr[$];
    logic [1:0]    exp_err[$];

    int            rd_addr[2];
    int            rd_err[2];
    int            strob_len[2];
    int            busy_len[2];
    logic          prev_strob[2];
    logic          prev_busy[2];
    logic          prev_err[2];
    logic [AW-1:0] last_addr[2];

    function automatic logic [7:0] frame_of(input logic [AW-1:0] a);
`ifdef CMD_RX_PARITY_EN
        return {2'b00, a, ^a};
`else
        return {3'b000, a};
`endif
    endfunction

    task automatic clear_monitor();
        for (int d = 0; d < 2; d++) begin
            strob_len[d]  = 0;
            busy_len[d]   = 0;
            prev_strob[d] = 1'b0;
            prev_busy[d]  = 1'b0;
            prev_err[d]   = 1'b0;
            last_addr[d]  = '0;
        end
    endtask

    // Scoreboard monitor for one receiver, called once per cycle after the edge.
    task automatic observe(input int d);
        logic [AW-1:0] a;
        logic [AW-1:0] ea;
        logic [1:0]    c;
        logic [1:0]    ec;
        logic          s, b, e;
        int            sl, bl;
        a  = (d == 0) ? addr_a  : addr_b;
        s  = (d == 0) ? strob_a : strob_b;
        b  = (d == 0) ? busy_a  : busy_b;
        e  = (d == 0) ? err_a   : err_b;
        c  = (d == 0) ? code_a  : code_b;
        sl = (d == 0) ? SL0 : SL1;
        bl = 1 + sl + ((d == 0) ? GC0 : GC1);
        ea = (rd_addr[d] < exp_addr.size()) ? exp_addr[rd_addr[d]] : 'x;

        if (a !== last_addr[d]) begin
            n_checks++;
            if (rd_addr[d] >= exp_addr.size() || a !== ea) begin
                n_fail++;
                $display("FAIL addr_change dut%0d cyc %0d: addr_out=%h, expected next accepted %h",
                         d, cyc, a, ea);
            end
            last_addr[d] = a;
        end

        if (s && !prev_strob[d]) begin
            n_checks++;
            if (rd_addr[d] >= exp_addr.size()) begin
                n_fail++;
                $display("FAIL strobe_expected dut%0d cyc %0d: strobe seen, no frame pending", d, cyc);
            end else begin
                if (a !== ea) begin
                    n_fail++;
                    $display("FAIL strobe_addr dut%0d: addr_out=%h, expected %h", d, a, ea);
                end
                rd_addr[d]++;
            end
            n_checks++;
            if (cyc - fall_cyc != 2) begin
                n_fail++;
                $display("FAIL strobe_latency dut%0d: %0d cycles after frame low, expected 2",
                         d, cyc - fall_cyc);
            end
            strob_len[d] = 1;
        end else if (s) begin
            strob_len[d]++;
        end else if (prev_strob[d]) begin
            n_checks++;
            if (strob_len[d] != sl) begin
                n_fail++;
                $display("FAIL strobe_len dut%0d: %0d cycles, expected %0d", d, strob_len[d], sl);
            end
        end

        if (b && !prev_busy[d]) begin
            busy_len[d] = 1;
        end else if (b) begin
            busy_len[d]++;
        end else if (prev_busy[d]) begin
            n_checks++;
            if (busy_len[d] != bl) begin
                n_fail++;
                $display("FAIL busy_len dut%0d: %0d cycles, expected %0d", d, busy_len[d], bl);
            end
        end

        if (e && !prev_err[d]) begin
            n_checks++;
            ec = (rd_err[d] < exp_err.size()) ? exp_err[rd_err[d]] : 'x;
            if (rd_err[d] >= exp_err.size() || c !== ec) begin
                n_fail++;
                $display("FAIL err_code dut%0d cyc %0d: err_code=%0d, expected %0d", d, cyc, c, ec);
            end
            rd_err[d]++;
        end else if (e) begin
            n_checks++;
            n_fail++;
            $display("FAIL err_pulse dut%0d cyc %0d: err_out high for more than 1 cycle", d, cyc);
        end

        prev_strob[d] = s;
        prev_busy[d]  = b;
        prev_err[d]   = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        observe(0);
        observe(1);
    endtask

    // Drives n bits MSB first, then one cycle of ser_frame low.
    task automatic send_frame(input logic [7:0] bits, input int n);
        ser_frame = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            ser_valid = 1'b1;
            ser_data  = bits[i];
            tick();
        end
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_frame = 1'b0;
        fall_cyc  = cyc;
        tick();
    endtask

    task automatic check_steady(input string name, input logic [AW-1:0] ea, input logic [1:0] ec);
        for (int d = 0; d < 2; d++) begin
            logic [AW-1:0] a;
            logic [1:0]    c;
            logic          s;
            a = (d == 0) ? addr_a  : addr_b;
            c = (d == 0) ? code_a  : code_b;
            s = (d == 0) ? strob_a : strob_b;
            n_checks++;
            if (a !== ea || c !== ec || s !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d: addr=%h code=%0d strob=%b, expected addr=%h code=%0d strob=0",
                         name, d, a, c, s, ea, ec);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_monitor();
        for (int d = 0; d < 2; d++) begin
            rd_addr[d] = 0;
            rd_err[d]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({addr_a, strob_a, busy_a, err_a, code_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: addr=%h strob=%b busy=%b err=%b code=%0d, expected all 0",
                     addr_a, strob_a, busy_a, err_a, code_a);
        end
        n_checks++;
        if ({addr_b, strob_b, busy_b, err_b, code_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: addr=%h strob=%b busy=%b err=%b code=%0d, expected all 0",
                     addr_b, strob_b, busy_b, err_b, code_b);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        exp_addr.push_back(5'h13);
        send_frame(frame_of(5'h13), NB);
        repeat (12) tick();
        check_steady("good_frame", 5'h13, 2'd0);
    endtask

    task automatic test_short();
        exp_err.push_back(2'd1);
        send_frame(8'b101, 3);
        repeat (4) tick();
        check_steady("short_frame", 5'h13, 2'd1);
    endtask

    task automatic test_long();
        exp_err.push_back(2'd2);
        send_frame(8'hA5, NB + 2);
        exp_addr.push_back(5'h0A);
        send_frame(frame_of(5'h0A), NB);
        repeat (12) tick();
        check_steady("long_then_good", 5'h0A, 2'd0);
    endtask

    task automatic test_busy();
        exp_addr.push_back(5'h07);
        send_frame(frame_of(5'h07), NB);
        tick();
        exp_err.push_back(2'd3);
        send_frame(frame_of(5'h1F), NB);
        repeat (12) tick();
        check_steady("busy_frame", 5'h07, 2'd3);
    endtask

`ifdef CMD_RX_PARITY_EN
    task automatic test_parity();
        exp_addr.push_back(5'h13);
        send_frame({2'b00, 5'h13, 1'b1}, 6);
        repeat (12) tick();
        exp_err.push_back(2'd3);
        send_frame({2'b00, 5'h13, 1'b0}, 6);
        repeat (6) tick();
        check_steady("parity_bad", 5'h13, 2'd3);
    endtask
`endif

    task automatic test_reset_mid_strobe();
        exp_addr.push_back(5'h1C);
        send_frame(frame_of(5'h1C), NB);
        tick();
        n_checks++;
        if (strob_a !== 1'b1 || strob_b !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_strobe: strob_a=%b strob_b=%b, expected 1 1", strob_a, strob_b);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (strob_a !== 1'b0 || strob_b !== 1'b0 || addr_a !== '0 || addr_b !== '0) begin
            n_fail++;
            $display("FAIL async_reset: strob=%b%b addr=%h/%h, expected strob 00 addr 00/00",
                     strob_a, strob_b, addr_a, addr_b);
        end
        clear_monitor();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        exp_addr.push_back(5'h05);
        send_frame(frame_of(5'h05), NB);
        repeat (12) tick();
        check_steady("after_reset", 5'h05, 2'd0);
    endtask

    task automatic test_drained();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rd_addr[d] != exp_addr.size() || rd_err[d] != exp_err.size()) begin
                n_fail++;
                $display("FAIL scoreboard_drain dut%0d: strobes %0d/%0d errors %0d/%0d",
                         d, rd_addr[d], exp_addr.size(), rd_err[d], exp_err.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short();
        test_long();
        test_busy();
`ifdef CMD_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_strobe();
        test_drained();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
